// File: rtl/sram_controller.sv
// MEM-stage front end for a 32-bit asynchronous SRAM (17-bit word address,
// active-low write enable, bidirectional data bus).
//
// Accepts one read or write request at a time from the MEM pipeline stage,
// maps the byte address to an SRAM word address, then holds the SRAM bus
// for ACCESS_CYCLES cycles while stalling the pipeline through `ready`.
//
// Parameters:
//   ACCESS_CYCLES  cycles the SRAM bus is held per access (1..15)
//   BASE_ADDR      byte address that maps to SRAM word 0
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   wr_en       write request (level, held until ready)
//   rd_en       read request (level, held until ready)
//   address     byte address from the ALU
//   write_data  store data
//   read_data   registered load data
//   ready       1 = pipeline may advance, 0 = freeze
//   SRAM_WE_N   SRAM write enable, active low
//   SRAM_ADDR   registered SRAM word address
//   SRAM_DQ     SRAM bidirectional data bus

module sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        SRAM_WE_N,
    output logic [16:0] SRAM_ADDR,
    inout  wire  [31:0] SRAM_DQ
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic        wr_op_q, wr_op_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wdata_q;

    logic        req;
    logic [31:0] offset;
    logic        drive_bus;
    logic        unused_offset_bits;

    assign req    = wr_en | rd_en;
    // Modulo-2^32 subtraction; addresses below BASE_ADDR wrap into the
    // top of the SRAM rather than being rejected.
    assign offset = address - BASE_ADDR;

    // Byte-offset bits and bits beyond the SRAM depth are dropped.
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_op_d = wr_op_q;
        rdata_d = rdata_q;
        ready   = 1'b1;

        unique case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    addr_d  = offset[18:2];
                    // A simultaneous read+write is treated as a write.
                    wr_op_d = wr_en;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ready = 1'b0;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    if (!wr_op_q) begin
                        rdata_d = SRAM_DQ;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // Requests still present here belong to the access that
                // is finishing; the pipeline advances on this edge.
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 17'd0;
            wr_op_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_op_q <= wr_op_d;
            rdata_q <= rdata_d;
        end
    end

    // Store data is a pure datapath register; it is only ever observed
    // while a write is in ACCESS, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            wdata_q <= write_data;
        end
    end

    // Gating with rst releases the bus in the same instant reset rises,
    // independent of how the state register settles.
    assign drive_bus = (state_q == ACCESS) & wr_op_q & ~rst;

    assign SRAM_WE_N = ~drive_bus;
    assign SRAM_DQ   = drive_bus ? wdata_q : 32'bz;
    assign SRAM_ADDR = addr_q;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM model.
// Vector table covers the main accesses; reset cases are hand sequenced.

module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        SRAM_WE_N;
    logic [16:0] SRAM_ADDR;
    wire  [31:0] SRAM_DQ;

    logic        sram_drive;
    logic [31:0] mem [0:1023];
    int          cyc;
    int          n_checks;
    int          n_fail;

    sram_controller #(
        .ACCESS_CYCLES(5),
        .BASE_ADDR(32'd1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .ready(ready),
        .SRAM_WE_N(SRAM_WE_N),
        .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ(SRAM_DQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: preloaded while reset is held, otherwise written
    // on every rising edge with WE_N low.
    always @(posedge clk) begin
        if (rst) begin
            mem[2] <= 32'h0000000A;
            mem[3] <= 32'h0000000B;
        end else if (!SRAM_WE_N) begin
            mem[SRAM_ADDR[9:0]] <= SRAM_DQ;
        end
    end

    assign SRAM_DQ = (sram_drive && SRAM_WE_N) ? mem[SRAM_ADDR[9:0]] : 32'bz;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [16:0] exp_addr;
        int          exp_we;
        logic [31:0] exp_rdata;
        logic        gap_chk;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Count stalled cycles from the current sample point until ready.
    task automatic measure(input logic [31:0] wd, output int low,
                           output int we, output logic dq_ok);
        low   = 0;
        we    = 0;
        dq_ok = 1'b1;
        while (!ready && low < 20) begin
            if (!SRAM_WE_N) begin
                we++;
                if (SRAM_DQ !== wd) dq_ok = 1'b0;
            end
            low++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v, output int low, output int we,
                           output logic dq_ok);
        @(negedge clk);
        wr_en      = v.wr;
        rd_en      = v.rd;
        address    = v.addr;
        write_data = v.wdata;
        #1;
        measure(v.wdata, low, we, dq_ok);
    endtask

    initial begin
        int   low;
        int   we;
        logic dq_ok;
        int   prev_done;

        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        prev_done  = 0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        sram_drive = 1'b1;

        vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 17'd1, 5, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h0BADF00D, 17'd1, 0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 17'd0, 5, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h0BADF00D, 17'd0, 0, 32'h12345678, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'd1032, 32'h0BADF00D, 17'd2, 0, 32'h0000000A, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 17'd3, 0, 32'h0000000B, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'd0, 32'h00000005, 17'h1FF00, 5, 32'h0000000B, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 32'd1027, 32'h0BADF00D, 17'd0, 0, 32'h12345678, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_ready", {31'b0, ready}, 32'd1);
        chk("idle_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        chk("idle_rdata", read_data, 32'd0);
        chk("idle_addr", {15'b0, SRAM_ADDR}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], low, we, dq_ok);
            chk($sformatf("v%0d_stall", i), low, 32'd6);
            chk($sformatf("v%0d_we_cycles", i), we, vecs[i].exp_we);
            if (vecs[i].exp_we > 0)
                chk($sformatf("v%0d_dq", i), {31'b0, dq_ok}, 32'd1);
            chk($sformatf("v%0d_sram_addr", i), {15'b0, SRAM_ADDR},
                {15'b0, vecs[i].exp_addr});
            chk($sformatf("v%0d_rdata", i), read_data, vecs[i].exp_rdata);
            chk($sformatf("v%0d_done_we_n", i), {31'b0, SRAM_WE_N}, 32'd1);
            if (vecs[i].gap_chk)
                chk($sformatf("v%0d_ready_gap", i), cyc - prev_done, 32'd7);
            prev_done = cyc;
        end

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        sram_drive = 1'b0;

        // Reset asserted between edges: outputs must change at once.
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_addr", {15'b0, SRAM_ADDR}, 32'd0);
        chk("rst_dq_released", {31'b0, SRAM_DQ !== 32'h0BADF00D}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the 3rd ACCESS cycle of a write.
        @(negedge clk);
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        address    = 32'd1028;
        write_data = 32'h5555AAAA;
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
        end
        chk("mid_we_low", {31'b0, SRAM_WE_N}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        chk("mid_rst_idle", {31'b0, ready}, 32'd0);
        chk("mid_rst_dq", {31'b0, SRAM_DQ !== 32'h5555AAAA}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        measure(32'h5555AAAA, low, we, dq_ok);
        chk("mid_restart_stall", low, 32'd6);
        chk("mid_restart_we", we, 32'd5);
        chk("mid_restart_dq", {31'b0, dq_ok}, 32'd1);
        chk("mid_restart_addr", {15'b0, SRAM_ADDR}, 32'd1);

        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        #1;
        chk("end_ready", {31'b0, ready}, 32'd1);
        chk("end_we_n", {31'b0, SRAM_WE_N}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
